// File: rtl/bypass_rf_pkg.sv
// Shared types and constants for the bypass regfile client: FSM state
// encoding, default widths and the saturating statistics counter helper.
package bypass_rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NAME_W = 2;
    localparam int STAT_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [NAME_W-1:0] name_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RES  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RSP  = 3'd3,
        ST_WB   = 3'd4,
        ST_FREE = 3'd5
    } state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bypass_rf_opnd_capture.sv
// Sticky capture of one read port's data: latches the first valid beat
// while enabled and holds it until the operand is freed.
module bypass_rf_opnd_capture #(
    parameter int data_width = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  valid,
    input  logic [data_width-1:0] d,
    input  logic                  clear,
    output logic                  vld,
    output logic                  vld_next,
    output logic [data_width-1:0] data
);

    // Lets the FSM leave WAIT in the same cycle the last operand arrives.
    assign vld_next = vld | (en & valid);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (en && valid && !vld) begin
            vld  <= 1'b1;
            data <= d;
        end
    end

endmodule

// File: rtl/bypass_rf_client.sv
// Single-instruction sequencer for the bypass regfile reserve/read/write/free
// protocol. Optional stall counters: define BYPASS_RF_CLIENT_STATS_EN.
module bypass_rf_client
    import bypass_rf_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int data_width = DATA_W,
    parameter int name_width = NAME_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [addr_width-1:0] req_rs1,
    input  logic [addr_width-1:0] req_rs2,
    input  logic [addr_width-1:0] req_rd,
    input  logic                  req_wr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_d1,
    output logic [data_width-1:0] rsp_d2,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [data_width-1:0] wb_data,
    output logic [addr_width-1:0] rf_addr_in,
    output logic                  rf_alloc_e,
    input  logic                  rf_alloc_ready,
    input  logic [name_width-1:0] rf_name_in,
    output logic [addr_width-1:0] rf_addr_1,
    output logic [addr_width-1:0] rf_addr_2,
    output logic                  rf_rrese_1,
    output logic                  rf_rrese_2,
    input  logic                  rf_rres_ready_1,
    input  logic                  rf_rres_ready_2,
    input  logic [name_width-1:0] rf_rname_1,
    input  logic [name_width-1:0] rf_rname_2,
    output logic [name_width-1:0] rf_rd_name_1,
    output logic [name_width-1:0] rf_rd_name_2,
    input  logic [data_width-1:0] rf_d_1,
    input  logic [data_width-1:0] rf_d_2,
    input  logic                  rf_valid_1,
    input  logic                  rf_valid_2,
    output logic                  rf_fe_1,
    output logic                  rf_fe_2,
    output logic                  rf_we,
    output logic [name_width-1:0] rf_wname,
    output logic [data_width-1:0] rf_wdata,
    output logic [name_width-1:0] rf_wf,
    output logic                  rf_wfe,
`ifdef BYPASS_RF_CLIENT_STATS_EN
    output logic [STAT_W-1:0]     stat_res_stall,
    output logic [STAT_W-1:0]     stat_wait_stall,
`endif
    input  logic                  rf_f_ready
);

    state_t                  state_reg;
    logic [addr_width-1:0]   rs1_reg, rs2_reg, rd_reg;
    logic                    wr_reg;
    logic [name_width-1:0]   rname1_reg, rname2_reg, wname_reg;
    logic                    req_ready_reg, rsp_valid_reg, wb_ready_reg, wfe_reg;

    logic                    res_ok, res_fire, rsp_fire, wb_fire, cap_en;
    logic [1:0]              cap_valid_in, cap_vld, cap_vld_next;
    logic [data_width-1:0]   cap_d_in [2];
    logic [data_width-1:0]   cap_data [2];

    // All three slots are granted in one cycle or none are.
    assign res_ok   = rf_rres_ready_1 & rf_rres_ready_2 & (~wr_reg | rf_alloc_ready);
    assign res_fire = (state_reg == ST_RES) & res_ok;
    assign rsp_fire = rsp_valid_reg & rsp_ready;
    assign wb_fire  = wb_ready_reg & wb_valid;
    assign cap_en   = (state_reg == ST_WAIT);

    assign cap_valid_in = {rf_valid_2, rf_valid_1};
    assign cap_d_in[0]  = rf_d_1;
    assign cap_d_in[1]  = rf_d_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cap
            bypass_rf_opnd_capture #(.data_width(data_width)) u_cap (
                .CLK      (CLK),
                .RST      (RST),
                .en       (cap_en),
                .valid    (cap_valid_in[gi]),
                .d        (cap_d_in[gi]),
                .clear    (rsp_fire),
                .vld      (cap_vld[gi]),
                .vld_next (cap_vld_next[gi]),
                .data     (cap_data[gi])
            );
        end
    endgenerate

    assign req_ready    = req_ready_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_d1       = cap_data[0];
    assign rsp_d2       = cap_data[1];
    assign wb_ready     = wb_ready_reg;
    assign rf_addr_1    = rs1_reg;
    assign rf_addr_2    = rs2_reg;
    assign rf_addr_in   = rd_reg;
    assign rf_rrese_1   = res_fire;
    assign rf_rrese_2   = res_fire;
    assign rf_alloc_e   = res_fire & wr_reg;
    assign rf_rd_name_1 = rname1_reg;
    assign rf_rd_name_2 = rname2_reg;
    assign rf_fe_1      = rsp_fire;
    assign rf_fe_2      = rsp_fire;
    assign rf_we        = wb_fire;
    assign rf_wname     = wname_reg;
    assign rf_wdata     = wb_fire ? wb_data : '0;
    assign rf_wf        = wname_reg;
    assign rf_wfe       = wfe_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            wr_reg        <= 1'b0;
            rname1_reg    <= '0;
            rname2_reg    <= '0;
            wname_reg     <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            wb_ready_reg  <= 1'b0;
            wfe_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_ready_reg && req_valid) begin
                        rs1_reg       <= req_rs1;
                        rs2_reg       <= req_rs2;
                        rd_reg        <= req_rd;
                        wr_reg        <= req_wr;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_RES;
                    end
                end
                ST_RES: begin
                    if (res_ok) begin
                        rname1_reg <= rf_rname_1;
                        rname2_reg <= rf_rname_2;
                        if (wr_reg) wname_reg <= rf_name_in;
                        state_reg  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (&cap_vld_next) begin
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        if (wr_reg) begin
                            wb_ready_reg <= 1'b1;
                            state_reg    <= ST_WB;
                        end else begin
                            req_ready_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end
                    end
                end
                ST_WB: begin
                    if (wb_valid) begin
                        wb_ready_reg <= 1'b0;
                        wfe_reg      <= 1'b1;
                        state_reg    <= ST_FREE;
                    end
                end
                ST_FREE: begin
                    if (rf_f_ready) begin
                        wfe_reg       <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef BYPASS_RF_CLIENT_STATS_EN
    logic [STAT_W-1:0] res_stall_reg, wait_stall_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_stall_reg  <= '0;
            wait_stall_reg <= '0;
        end else begin
            if (state_reg == ST_RES && !res_ok) res_stall_reg <= sat_inc(res_stall_reg);
            if (state_reg == ST_WAIT) wait_stall_reg <= sat_inc(wait_stall_reg);
        end
    end

    assign stat_res_stall  = res_stall_reg;
    assign stat_wait_stall = wait_stall_reg;
`endif

endmodule

// File: tb/tb_bypass_rf_client.sv
// Table-driven bench for bypass_rf_client with a scoreboard for operand
// responses and writebacks, plus a hand-written async-reset sequence.
module tb_bypass_rf_client;
    import bypass_rf_pkg::*;

    logic        CLK, RST;
    logic        req_valid, req_ready, req_wr;
    logic [4:0]  req_rs1, req_rs2, req_rd;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_d1, rsp_d2;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  rf_addr_in, rf_addr_1, rf_addr_2;
    logic        rf_alloc_e, rf_alloc_ready;
    logic [1:0]  rf_name_in, rf_rname_1, rf_rname_2, rf_rd_name_1, rf_rd_name_2;
    logic        rf_rrese_1, rf_rrese_2, rf_rres_ready_1, rf_rres_ready_2;
    logic [31:0] rf_d_1, rf_d_2;
    logic        rf_valid_1, rf_valid_2, rf_fe_1, rf_fe_2, rf_we, rf_wfe, rf_f_ready;
    logic [1:0]  rf_wname, rf_wf;
    logic [31:0] rf_wdata;
`ifdef BYPASS_RF_CLIENT_STATS_EN
    logic [31:0] stat_res_stall, stat_wait_stall;
`endif

    bypass_rf_client dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_rd(req_rd), .req_wr(req_wr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .rf_addr_in(rf_addr_in), .rf_alloc_e(rf_alloc_e), .rf_alloc_ready(rf_alloc_ready),
        .rf_name_in(rf_name_in),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
        .rf_rrese_1(rf_rrese_1), .rf_rrese_2(rf_rrese_2),
        .rf_rres_ready_1(rf_rres_ready_1), .rf_rres_ready_2(rf_rres_ready_2),
        .rf_rname_1(rf_rname_1), .rf_rname_2(rf_rname_2),
        .rf_rd_name_1(rf_rd_name_1), .rf_rd_name_2(rf_rd_name_2),
        .rf_d_1(rf_d_1), .rf_d_2(rf_d_2), .rf_valid_1(rf_valid_1), .rf_valid_2(rf_valid_2),
        .rf_fe_1(rf_fe_1), .rf_fe_2(rf_fe_2),
        .rf_we(rf_we), .rf_wname(rf_wname), .rf_wdata(rf_wdata),
        .rf_wf(rf_wf), .rf_wfe(rf_wfe),
`ifdef BYPASS_RF_CLIENT_STATS_EN
        .stat_res_stall(stat_res_stall), .stat_wait_stall(stat_wait_stall),
`endif
        .rf_f_ready(rf_f_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        wr;
        logic [1:0]  n1, n2, wn;
        logic [31:0] d1, d2, wbd;
        int          res_stall, v1d, v2d, rsp_hold, wb_delay, free_stall;
    } vec_t;

    typedef struct { logic [31:0] d1, d2; } rsp_exp_t;
    typedef struct { logic [1:0] wn; logic [31:0] wbd; } wb_exp_t;

    vec_t     vecs [7];
    rsp_exp_t rsp_q [$];
    wb_exp_t  wb_q  [$];
    int       checks = 0;
    int       errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input int idx);
        vec_t     v;
        rsp_exp_t re;
        wb_exp_t  we;
        int       nwait;
        v = vecs[idx];
        $display("op %0d: rs1=%0d rs2=%0d rd=%0d wr=%0b", idx, v.rs1, v.rs2, v.rd, v.wr);
        req_valid = 1'b1; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rd = v.rd; req_wr = v.wr;
        #1 check("req_ready_idle", req_ready, 1);
        tick;
        req_valid = 1'b0;
        rf_rname_1 = v.n1; rf_rname_2 = v.n2; rf_name_in = v.wn;
        rf_rres_ready_1 = 1'b1; rf_alloc_ready = 1'b1;
        for (int s = 0; s < v.res_stall; s++) begin
            rf_rres_ready_2 = 1'b0;
            #1 check("res_stall_en", {rf_rrese_1, rf_rrese_2, rf_alloc_e}, 3'b000);
            check("req_ready_busy", req_ready, 0);
            tick;
        end
        rf_rres_ready_2 = 1'b1;
        #1 check("res_en", {rf_rrese_1, rf_rrese_2, rf_alloc_e}, {2'b11, v.wr});
        check("rf_addr", {rf_addr_1, rf_addr_2, rf_addr_in}, {v.rs1, v.rs2, v.rd});
        tick;
        rf_rres_ready_1 = 1'b0; rf_rres_ready_2 = 1'b0; rf_alloc_ready = 1'b0;
        rf_rname_1 = ~v.n1; rf_rname_2 = ~v.n2; rf_name_in = ~v.wn;
        // scoreboard: expected operands are known once the regfile data is chosen
        re.d1 = v.d1; re.d2 = v.d2;
        rsp_q.push_back(re);
        nwait = (v.v1d > v.v2d) ? v.v1d : v.v2d;
        for (int c = 0; c <= nwait; c++) begin
            rf_valid_1 = (c == v.v1d); rf_d_1 = (c == v.v1d) ? v.d1 : ~v.d1;
            rf_valid_2 = (c == v.v2d); rf_d_2 = (c == v.v2d) ? v.d2 : ~v.d2;
            #1 check("wait_rsp_valid", rsp_valid, 0);
            if (c == 0) check("rd_names", {rf_rd_name_1, rf_rd_name_2}, {v.n1, v.n2});
            tick;
        end
        rf_valid_1 = 1'b0; rf_valid_2 = 1'b0; rf_d_1 = 32'hBAD0_0001; rf_d_2 = 32'hBAD0_0002;
        for (int h = 0; h < v.rsp_hold; h++) begin
            rsp_ready = 1'b0;
            #1 check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_fe", {rf_fe_1, rf_fe_2}, 2'b00);
            tick;
        end
        rsp_ready = 1'b1;
        #1 check("rsp_valid", rsp_valid, 1);
        if (rsp_q.size() == 0) begin
            check("rsp_q_empty", 1, 0);
        end else begin
            re = rsp_q.pop_front();
            check("rsp_d1", rsp_d1, re.d1);
            check("rsp_d2", rsp_d2, re.d2);
        end
        check("rf_fe", {rf_fe_1, rf_fe_2}, 2'b11);
        tick;
        rsp_ready = 1'b0;
        #1 check("rf_fe_pulse", {rf_fe_1, rf_fe_2, rsp_valid}, 3'b000);
        if (!v.wr) begin
            check("nowr_idle", {req_ready, wb_ready, rf_we, rf_wfe}, 4'b1000);
            return;
        end
        check("wb_ready", wb_ready, 1);
        for (int w = 0; w < v.wb_delay; w++) begin
            wb_valid = 1'b0; wb_data = 32'hFFFF_FFFF;
            #1 check("wb_wait_we", rf_we, 0);
            tick;
        end
        wb_valid = 1'b1; wb_data = v.wbd;
        we.wn = v.wn; we.wbd = v.wbd;
        wb_q.push_back(we);
        #1 check("rf_we", rf_we, 1);
        if (wb_q.size() == 0) begin
            check("wb_q_empty", 1, 0);
        end else begin
            we = wb_q.pop_front();
            check("rf_wname", rf_wname, we.wn);
            check("rf_wdata", rf_wdata, we.wbd);
        end
        tick;
        wb_valid = 1'b0;
        #1 check("rf_we_pulse", {rf_we, wb_ready}, 2'b00);
        for (int f = 0; f < v.free_stall; f++) begin
            rf_f_ready = 1'b0;
            #1 check("free_hold", {rf_wfe, rf_wf}, {1'b1, v.wn});
            tick;
        end
        rf_f_ready = 1'b1;
        #1 check("free_fire", {rf_wfe, rf_wf}, {1'b1, v.wn});
        tick;
        rf_f_ready = 1'b0;
        #1 check("free_done", {rf_wfe, req_ready}, 2'b01);
    endtask

    initial begin
        vecs[0] = '{5'd3, 5'd4, 5'd5, 1'b1, 2'd1, 2'd2, 2'd3, 32'hA1A1_0003, 32'hB2B2_0004, 32'h0000_DEAD, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{5'd7, 5'd8, 5'd9, 1'b1, 2'd2, 2'd3, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 3, 0, 0, 0, 0, 0};
        vecs[2] = '{5'd1, 5'd2, 5'd6, 1'b1, 2'd0, 2'd1, 2'd2, 32'h0000_0011, 32'h0000_0022, 32'hCAFE_0001, 0, 0, 3, 0, 0, 0};
        vecs[3] = '{5'd10, 5'd11, 5'd12, 1'b0, 2'd3, 2'd0, 2'd0, 32'h5555_AAAA, 32'hAAAA_5555, 32'h0, 0, 1, 1, 1, 0, 0};
        vecs[4] = '{5'd13, 5'd14, 5'd15, 1'b1, 2'd1, 2'd1, 2'd2, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h7777_1111, 0, 0, 0, 0, 0, 4};
        vecs[5] = '{5'd20, 5'd20, 5'd20, 1'b1, 2'd2, 2'd0, 2'd3, 32'hDEAD_BEEF, 32'hFEED_FACE, 32'h2468_ACE0, 1, 2, 0, 2, 2, 1};
        vecs[6] = '{5'd31, 5'd0, 5'd17, 1'b1, 2'd3, 2'd2, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 2, 0, 0, 1, 0};

        RST = 1'b1;
        req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0; req_wr = 0;
        rsp_ready = 0; wb_valid = 0; wb_data = 0;
        rf_alloc_ready = 0; rf_name_in = 0; rf_rres_ready_1 = 0; rf_rres_ready_2 = 0;
        rf_rname_1 = 0; rf_rname_2 = 0; rf_d_1 = 0; rf_d_2 = 0;
        rf_valid_1 = 0; rf_valid_2 = 0; rf_f_ready = 0;

        #1 check("reset_outs", {req_ready, rsp_valid, wb_ready, rf_rrese_1, rf_rrese_2,
                                rf_alloc_e, rf_fe_1, rf_fe_2, rf_we, rf_wfe}, 10'd0);
        tick; tick;
        RST = 1'b0;
        #1 check("req_ready_pre_edge", req_ready, 0);
        tick;
        check("req_ready_post_reset", req_ready, 1);

        for (int i = 0; i < 7; i++) run_op(i);

        // async reset while parked in WAIT, between clock edges
        $display("op reset: reset asserted in WAIT");
        req_valid = 1'b1; req_rs1 = 5'd9; req_rs2 = 5'd10; req_rd = 5'd11; req_wr = 1'b1;
        tick;
        req_valid = 1'b0;
        rf_rres_ready_1 = 1; rf_rres_ready_2 = 1; rf_alloc_ready = 1;
        rf_rname_1 = 2'd3; rf_rname_2 = 2'd2; rf_name_in = 2'd1;
        tick;
        rf_rres_ready_1 = 0; rf_rres_ready_2 = 0; rf_alloc_ready = 0;
        tick; tick;
        #1 check("wait_names", {rf_rd_name_1, rf_rd_name_2, rf_addr_1}, {2'd3, 2'd2, 5'd9});
        #1 RST = 1'b1;
        #1 check("async_rst_outs", {req_ready, rsp_valid, wb_ready, rf_rrese_1, rf_rrese_2,
                                    rf_alloc_e, rf_fe_1, rf_fe_2, rf_we, rf_wfe}, 10'd0);
        check("async_rst_regs", {rf_rd_name_1, rf_rd_name_2, rf_addr_1, rf_addr_2, rf_addr_in}, 19'd0);
        tick;
        RST = 1'b0;
        #1 check("rst_req_ready_pre", req_ready, 0);
        tick;
        check("rst_req_ready_post", {req_ready, rf_wfe, rf_fe_1}, 3'b100);

        run_op(0);

        check("sb_drained", rsp_q.size() + wb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
